// File: rtl/cdb_pkg.sv
// Shared CDB definitions: functional-unit ids, default sizing and the arbiter FSM state type.
package cdb_pkg;

  localparam int NUM_FU_DEF  = 4;
  localparam int FU_ID_W_DEF = 4;

  localparam int FU_ALU    = 0;
  localparam int FU_BRANCH = 1;
  localparam int FU_LSU    = 2;
  localparam int FU_MUL    = 3;

  typedef enum logic {
    RUN     = 1'b0,
    BLOCKED = 1'b1
  } cdb_state_e;

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or above ptr, wrapping.
// Returns a one-hot grant, its binary index, and whether any request was present.
import cdb_pkg::*;

module cdb_rr_pick #(
  parameter int N     = NUM_FU_DEF,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0]  dreq;
  logic [N-1:0]    rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]  sum;

  always_comb begin
    dreq = {req, req} >> ptr;
    rot  = dreq[N-1:0];
    any  = 1'b0;
    off  = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        off = IDX_W'(k);
      end
    end
    // Rotated offset back to an absolute FU index, modulo N.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    idx = sum[IDX_W-1:0];
    gnt = '0;
    for (int i = 0; i < N; i++) gnt[i] = any && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one registered one-hot ack per cycle, ROB back-pressure FSM, starvation monitor.
// Define CDB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
import cdb_pkg::*;

module cdb_arbiter #(
  parameter int NUM_FU       = NUM_FU_DEF,
  parameter int FU_ID_W      = FU_ID_W_DEF,
  parameter int STARVE_LIMIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_FU-1:0]  fu_req,
  input  logic               rob_full,
  output logic [NUM_FU-1:0]  fu_ack,
  output logic               cdb_valid,
  output logic [FU_ID_W-1:0] cdb_fu_id,
  output logic               starve_err
);

  localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_LIMIT);

  cdb_state_e         state, state_nxt;
  logic [PTR_W-1:0]   pick_ptr;
  logic [NUM_FU-1:0]  pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               grant_en;
  logic               starve_hit;
  logic [WAIT_W-1:0]  wait_cnt [NUM_FU];
  logic [WAIT_W-1:0]  wait_nxt [NUM_FU];

  assign grant_en = !rob_full;

  cdb_rr_pick #(
    .N     (NUM_FU),
    .IDX_W (PTR_W)
  ) u_pick (
    .req (fu_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef CDB_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [PTR_W-1:0] ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_en && pick_any) begin
      ptr <= (pick_idx == PTR_W'(NUM_FU - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  assign pick_ptr = ptr;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (rob_full)  state_nxt = BLOCKED;
      BLOCKED: if (!rob_full) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Waits count only on edges that actually arbitrate from RUN; BLOCKED freezes them.
  always_comb begin
    starve_hit = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      wait_nxt[i] = wait_cnt[i];
      if (!fu_req[i] || (grant_en && pick_gnt[i])) begin
        wait_nxt[i] = '0;
      end else if (state == RUN && grant_en && wait_cnt[i] != WAIT_MAX) begin
        wait_nxt[i] = wait_cnt[i] + 1'b1;
      end
      if (wait_nxt[i] >= WAIT_LIM) starve_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      fu_ack     <= '0;
      cdb_valid  <= 1'b0;
      cdb_fu_id  <= '0;
      starve_err <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) wait_cnt[i] <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (starve_hit) starve_err <= 1'b1;
      if (grant_en && pick_any) begin
        fu_ack    <= pick_gnt;
        cdb_valid <= 1'b1;
        cdb_fu_id <= FU_ID_W'(pick_idx);
      end else begin
        fu_ack    <= '0;
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule
